e_mdu_ctrl: RTL and testbench

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

---
 rtl/e_mdu_ctrl.sv | 150 +++++++++++++++
 tb/tb_e_mdu_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit controller: HI/LO registers, fixed-latency
// multiply (5 cycles) and divide (10 cycles) with a stall request for D-stage MD ops.
module e_mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_isMD,
    output logic        Busy,
    output logic        Stall_MD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic [31:0] pend_hi_r, pend_hi_s;
    logic [31:0] pend_lo_r, pend_lo_s;
    logic        div_zero_r, div_zero_s;
    logic        busy_r;

    logic        mul_signed_s;
    logic        div_signed_s;
    logic [63:0] op_a_s, op_b_s, prod_s;
    logic        neg_a_s, neg_b_s;
    logic [31:0] mag_a_s, mag_b_s, divisor_s;
    logic [31:0] uquot_s, urem_s, quot_s, rem_s;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Multiplier: sign-extend to 64 bits so one unsigned multiply serves MULT and MULTU
    assign mul_signed_s = (MDUOp == 4'd1);
    assign op_a_s       = {{32{mul_signed_s & A[31]}}, A};
    assign op_b_s       = {{32{mul_signed_s & B[31]}}, B};
    assign prod_s       = op_a_s * op_b_s;

    // Sign-magnitude divide; 0x80000000 / -1 falls out as 0x80000000 rem 0 naturally
    assign div_signed_s = (MDUOp == 4'd3);
    assign neg_a_s      = div_signed_s & A[31];
    assign neg_b_s      = div_signed_s & B[31];
    assign mag_a_s      = cond_neg(A, neg_a_s);
    assign mag_b_s      = cond_neg(B, neg_b_s);
    assign divisor_s    = (B == 32'd0) ? 32'd1 : mag_b_s;
    assign uquot_s      = mag_a_s / divisor_s;
    assign urem_s       = mag_a_s % divisor_s;
    assign quot_s       = cond_neg(uquot_s, neg_a_s ^ neg_b_s);
    assign rem_s        = cond_neg(urem_s, neg_a_s);

    // Next-state and next-register-value logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        pend_hi_s  = pend_hi_r;
        pend_lo_s  = pend_lo_r;
        div_zero_s = div_zero_r;
        case (state_r)
            IDLE: begin
                case (MDUOp)
                    4'd1, 4'd2: begin
                        pend_hi_s  = prod_s[63:32];
                        pend_lo_s  = prod_s[31:0];
                        div_zero_s = 1'b0;
                        cnt_s      = 4'd5;
                        state_s    = MUL_RUN;
                    end
                    4'd3, 4'd4: begin
                        pend_hi_s  = rem_s;
                        pend_lo_s  = quot_s;
                        div_zero_s = (B == 32'd0);
                        cnt_s      = 4'd10;
                        state_s    = DIV_RUN;
                    end
                    4'd7:    hi_s = A;
                    4'd8:    lo_s = A;
                    default: ;
                endcase
            end
            MUL_RUN, DIV_RUN: begin
                if (cnt_r == 4'd1) begin
                    if (!div_zero_r) begin
                        hi_s = pend_hi_r;
                        lo_s = pend_lo_r;
                    end else begin
                        hi_s = hi_r;
                    end
                    cnt_s   = 4'd0;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                cnt_s   = 4'd0;
                state_s = IDLE;
            end
        endcase
    end

    // State and architectural register update; reset aborts any run without commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            pend_hi_r  <= 32'd0;
            pend_lo_r  <= 32'd0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            pend_hi_r  <= pend_hi_s;
            pend_lo_r  <= pend_lo_s;
            div_zero_r <= div_zero_s;
            busy_r     <= (state_s != IDLE);
        end
    end

    // MFHI/MFLO read mux
    always_comb begin
        case (MDUOp)
            4'd5:    MD_out = hi_r;
            4'd6:    MD_out = lo_r;
            default: MD_out = 32'd0;
        endcase
    end

    assign Stall_MD = D_isMD & (busy_r | ((MDUOp >= 4'd1) && (MDUOp <= 4'd4)));
    assign Busy     = busy_r;
    assign HI       = hi_r;
    assign LO       = lo_r;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Bench for e_mdu_ctrl: table of MD operations with a result scoreboard,
// plus hand sequences for MTHI/MFHI, ops while busy, and mid-run reset.
module tb_e_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        D_isMD;
    logic        Busy, Stall_MD;
    logic [31:0] HI, LO, MD_out;

    e_mdu_ctrl dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B), .D_isMD(D_isMD),
        .Busy(Busy), .Stall_MD(Stall_MD), .HI(HI), .LO(LO), .MD_out(MD_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre;
        logic        dmd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with Busy high (bounded), checking Stall_MD on each
    task automatic wait_idle(input logic dmd, output int cycles);
        cycles = 0;
        while (Busy && cycles < 20) begin
            cycles++;
            chk("stall_run", {31'd0, Stall_MD}, {31'd0, dmd});
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'h0,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h0,        1'b0, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'h0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{4'd4, 32'd5,        32'd0,        32'h12345678, 1'b0, 32'h12345678, 32'h12345678, 10};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h55555555, 1'b0, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{4'd4, 32'd100,      32'd7,        32'h0,        1'b1, 32'h00000002, 32'h0000000E, 10};
        vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h0,        1'b0, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        1'b0, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[8] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 1'b1, 32'h00000000, 32'h00000001, 5};

        reset = 1'b1; MDUOp = 4'd0; A = 32'd0; B = 32'd0; D_isMD = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_mdout", MD_out, 32'd0);

        for (int i = 0; i < 9; i++) begin
            MDUOp = 4'd7; A = vecs[i].pre; tick();
            MDUOp = 4'd8; tick();
            MDUOp = vecs[i].op; A = vecs[i].a; B = vecs[i].b; D_isMD = vecs[i].dmd;
            #1;
            chk("stall_start", {31'd0, Stall_MD}, {31'd0, vecs[i].dmd});
            sb.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat});
            tick();
            MDUOp = 4'd0;
            #1;
            wait_idle(vecs[i].dmd, n);
            e = sb.pop_front();
            chk($sformatf("v%0d_hi", i), HI, e.hi);
            chk($sformatf("v%0d_lo", i), LO, e.lo);
            chk($sformatf("v%0d_latency", i), n, e.lat);
            chk($sformatf("v%0d_stall_after", i), {31'd0, Stall_MD}, 32'd0);
            D_isMD = 1'b0;
        end

        // MTHI then MFHI/MFLO reads and unused op codes
        MDUOp = 4'd7; A = 32'hCAFEBABE; tick();
        chk("mthi_hi", HI, 32'hCAFEBABE);
        MDUOp = 4'd5; #1;
        chk("mfhi", MD_out, 32'hCAFEBABE);
        MDUOp = 4'd6; #1;
        chk("mflo", MD_out, 32'h00000001);
        MDUOp = 4'd12; A = 32'h0BADF00D; tick();
        chk("op12_mdout", MD_out, 32'd0);
        chk("op12_hi", HI, 32'hCAFEBABE);
        chk("op12_busy", {31'd0, Busy}, 32'd0);

        // MTLO and a restart attempt while busy are both ignored
        MDUOp = 4'd1; A = 32'd2; B = 32'd3; D_isMD = 1'b0; tick();
        MDUOp = 4'd8; A = 32'hDEADBEEF; tick();
        MDUOp = 4'd1; A = 32'd9; B = 32'd9; tick();
        MDUOp = 4'd0;
        #1;
        wait_idle(1'b0, n);
        chk("busy_ops_latency", n, 3);
        chk("busy_ops_hi", HI, 32'd0);
        chk("busy_ops_lo", LO, 32'd6);

        // Reset three cycles into a multiply: no commit, MTHI on the reset edge ignored
        MDUOp = 4'd7; A = 32'h11111111; tick();
        MDUOp = 4'd8; tick();
        MDUOp = 4'd1; A = 32'd3; B = 32'd4; tick();
        MDUOp = 4'd0; tick(); tick();
        chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
        reset = 1'b1; MDUOp = 4'd7; A = 32'h0000FFFF; tick();
        reset = 1'b0; MDUOp = 4'd0;
        #1;
        chk("midreset_hi", HI, 32'd0);
        chk("midreset_lo", LO, 32'd0);
        chk("midreset_busy", {31'd0, Busy}, 32'd0);
        for (int k = 0; k < 8; k++) tick();
        chk("midreset_late_hi", HI, 32'd0);
        chk("midreset_late_lo", LO, 32'd0);
        chk("midreset_late_busy", {31'd0, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
